frame_buffer_dbl: RTL and testbench

//  Parametrised double-buffered (ping-pong) frame buffer, single clock. Camera/writer side fills
//  one bank while the VGA/reader side scans the other, so reader never sees a torn frame.

---
 rtl/frame_buffer_dbl_if.sv | 30 +++
 rtl/frame_buffer_dbl.sv | 123 ++++++++++++
 tb/tb_frame_buffer_dbl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_dbl_if.sv
// Writer/reader bus of the ping-pong frame buffer: pixel write port, frame pulses,
// freeze request and the registered read port with bank status.
interface frame_buffer_dbl_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
);
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [PIX_W-1:0]  wData;
    logic              w_frame_done;
    logic              frame_stop;
    logic              oe;
    logic [ADDR_W-1:0] rAddr;
    logic              r_frame_start;
    logic [PIX_W-1:0]  rData;
    logic              rValid;
    logic              rd_bank;
    logic              swap_pending;
    logic              frozen;

    modport master (
        output we, wAddr, wData, w_frame_done, frame_stop, oe, rAddr, r_frame_start,
        input  rData, rValid, rd_bank, swap_pending, frozen
    );

    modport slave (
        input  we, wAddr, wData, w_frame_done, frame_stop, oe, rAddr, r_frame_start,
        output rData, rValid, rd_bank, swap_pending, frozen
    );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame store: the writer fills one bank while the reader scans the other;
// banks swap only at a reader frame start once a complete frame is waiting.
module frame_buffer_dbl #(
    parameter  int H_RES  = 320,
    parameter  int V_RES  = 240,
    parameter  int PIX_W  = 12,
    localparam int DEPTH  = H_RES * V_RES,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    frame_buffer_dbl_if.slave  bus
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_ARM, ST_FROZEN} state_t;

    state_t state_q, state_d;
    logic   rd_bank_q, rd_bank_d;
    logic   pending_q, pending_d;
    logic   rvalid_q;
    logic   rd_inrange_q;
    logic   rd_sel_q;
    logic   frozen;
    logic   wr_bank;
    logic   done_ok;
    logic   wr_en;
    logic   swap;

    logic [1:0][PIX_W-1:0] bank_rd;

    assign wr_bank = ~rd_bank_q;
    assign done_ok = bus.w_frame_done && !frozen;
    assign wr_en   = bus.we && !frozen && (bus.wAddr < DEPTH_A);
    // A done in the same cycle as the reader's frame start swaps immediately.
    assign swap    = bus.r_frame_start && (pending_q || done_ok);

    // Freeze FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (bus.frame_stop) state_d = ST_ARM;
            ST_ARM: begin
                if (!bus.frame_stop)          state_d = ST_RUN;
                else if (bus.w_frame_done)    state_d = ST_FROZEN;
            end
            ST_FROZEN: if (!bus.frame_stop) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        frozen = (state_q == ST_FROZEN);
    end

    // Bank selection and the single owed swap
    always_comb begin
        rd_bank_d = rd_bank_q;
        pending_d = pending_q;
        if (swap) begin
            rd_bank_d = ~rd_bank_q;
            pending_d = 1'b0;
        end else if (done_ok) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank_q    <= 1'b1;
            pending_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rd_inrange_q <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            rd_bank_q <= rd_bank_d;
            pending_q <= pending_d;
            rvalid_q  <= bus.oe;
            if (bus.oe) begin
                rd_inrange_q <= (bus.rAddr < DEPTH_A);
                rd_sel_q     <= rd_bank_q;
            end
        end
    end

    // One block RAM per bank; the read word is registered inside the bank and only the
    // small select/range flags carry reset, so rData still returns to zero on reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [PIX_W-1:0] mem [DEPTH];
        logic [PIX_W-1:0] rd_word_q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == 1'(gi))) begin
                mem[bus.wAddr] <= bus.wData;
            end
        end

        always_ff @(posedge clk) begin
            if (bus.oe) begin
                rd_word_q <= mem[bus.rAddr];
            end
        end

        assign bank_rd[gi] = rd_word_q;
    end

    assign bus.rData        = rd_inrange_q ? bank_rd[rd_sel_q] : '0;
    assign bus.rValid       = rvalid_q;
    assign bus.rd_bank      = rd_bank_q;
    assign bus.swap_pending = pending_q;
    assign bus.frozen       = frozen;

    logic unused_v;
    assign unused_v = ^V_RES;
endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Scoreboard bench for frame_buffer_dbl: expected read data is queued when a read is
// issued and compared when rValid returns; status outputs are checked directly.
module tb_frame_buffer_dbl;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    frame_buffer_dbl_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    frame_buffer_dbl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [PIX_W-1:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Read-data monitor: one scoreboard pop per returned read
    always @(negedge clk) begin
        if (reset_n && bus.rValid) begin
            if (exp_q.size() == 0) begin
                check_val("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                check_val("rdata", 32'(bus.rData), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
        bus.we = 1'b1; bus.wAddr = a; bus.wData = d;
        step();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] e);
        bus.oe = 1'b1; bus.rAddr = a;
        exp_q.push_back(e);
        step();
        bus.oe = 1'b0;
    endtask

    task automatic pulse(input logic done, input logic start);
        bus.w_frame_done = done; bus.r_frame_start = start;
        step();
        bus.w_frame_done = 1'b0; bus.r_frame_start = 1'b0;
    endtask

    initial begin
        bus.we = 1'b0; bus.wAddr = '0; bus.wData = '0;
        bus.w_frame_done = 1'b0; bus.frame_stop = 1'b0;
        bus.oe = 1'b0; bus.rAddr = '0; bus.r_frame_start = 1'b0;

        #12;
        check_val("reset_rd_bank", 32'(bus.rd_bank), 32'd1);
        check_val("reset_pending", 32'(bus.swap_pending), 32'd0);
        check_val("reset_frozen", 32'(bus.frozen), 32'd0);
        check_val("reset_rvalid", 32'(bus.rValid), 32'd0);
        check_val("reset_rdata", 32'(bus.rData), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic frame into bank 0, then display it
        wr(17'd5, 12'hABC);
        pulse(1'b1, 1'b0);
        check_val("t1_pending", 32'(bus.swap_pending), 32'd1);
        pulse(1'b0, 1'b1);
        check_val("t1_rd_bank", 32'(bus.rd_bank), 32'd0);
        check_val("t1_pending_clr", 32'(bus.swap_pending), 32'd0);
        rd(17'd5, 12'hABC);

        // Frame start without a completed frame repeats the bank
        wr(17'd5, 12'h123);
        pulse(1'b0, 1'b1);
        check_val("t2_rd_bank", 32'(bus.rd_bank), 32'd0);
        rd(17'd5, 12'hABC);

        // Same-cycle done and frame start
        pulse(1'b1, 1'b1);
        check_val("t3_rd_bank", 32'(bus.rd_bank), 32'd1);
        check_val("t3_pending", 32'(bus.swap_pending), 32'd0);
        rd(17'd5, 12'h123);

        // Freeze on a frame boundary
        bus.frame_stop = 1'b1;
        step();
        check_val("t4_arm_frozen", 32'(bus.frozen), 32'd0);
        wr(17'd5, 12'h777);
        wr(17'd7, 12'h456);
        pulse(1'b1, 1'b0);
        check_val("t4_frozen", 32'(bus.frozen), 32'd1);
        check_val("t4_pending", 32'(bus.swap_pending), 32'd1);
        pulse(1'b0, 1'b1);
        check_val("t4_rd_bank", 32'(bus.rd_bank), 32'd0);
        rd(17'd5, 12'h777);
        rd(17'd7, 12'h456);
        wr(17'd5, 12'hFFF);
        pulse(1'b1, 1'b0);
        check_val("t4_done_ignored", 32'(bus.swap_pending), 32'd0);
        pulse(1'b0, 1'b1);
        check_val("t4_no_swap", 32'(bus.rd_bank), 32'd0);
        rd(17'd5, 12'h777);

        // Release; dropped 0xFFF must not appear in bank 1
        bus.frame_stop = 1'b0;
        step();
        check_val("t5_unfrozen", 32'(bus.frozen), 32'd0);
        wr(17'd7, 12'hBEE);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check_val("t5_rd_bank", 32'(bus.rd_bank), 32'd1);
        rd(17'd5, 12'h123);
        rd(17'd7, 12'hBEE);
        rd(17'd76800, 12'h000);

        // ARM aborted by frame_stop dropping before done
        bus.frame_stop = 1'b1;
        step();
        bus.frame_stop = 1'b0;
        step();
        wr(17'd76800, 12'h555);
        wr(17'd76799, 12'h3C3);
        pulse(1'b1, 1'b1);
        check_val("t5_abort_swap", 32'(bus.rd_bank), 32'd0);
        check_val("t5_abort_frozen", 32'(bus.frozen), 32'd0);
        rd(17'd76799, 12'h3C3);
        rd(17'd5, 12'h777);
        step();
        check_val("t5_rvalid_idle", 32'(bus.rValid), 32'd0);
        check_val("t5_rdata_hold", 32'(bus.rData), 32'h777);

        // Asynchronous reset while a swap is owed and a read is in flight
        pulse(1'b1, 1'b0);
        check_val("t6_pending_pre", 32'(bus.swap_pending), 32'd1);
        bus.oe = 1'b1; bus.rAddr = 17'd5;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_rd_bank", 32'(bus.rd_bank), 32'd1);
        check_val("t6_pending", 32'(bus.swap_pending), 32'd0);
        check_val("t6_rvalid", 32'(bus.rValid), 32'd0);
        check_val("t6_rdata", 32'(bus.rData), 32'd0);
        bus.oe = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check_val("t6_after_rd_bank", 32'(bus.rd_bank), 32'd1);
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
